parking_gate_ctrl: RTL

Sequencing controller in front of the parking floor/ID lookup block. Accepts one gate request at a time (enter, exit, admin restrict, admin unrestrict), presents the latched ID/mode/floor to the lookup block, evaluates the returned status flags, and issues the single-cycle `action_taken` command. Owns the three floor occupancy counters fed back to the lookup block and times the barrier gate.

---
 rtl/parking_pkg.sv | 41 ++++
 rtl/parking_gate_ctrl_if.sv | 32 +++
 rtl/floor_slot_counter.sv | 16 +
 rtl/parking_gate_ctrl.sv | 114 +++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// parking_pkg: state, command, result, mode and counter-select codes shared by the parking gate controller
package parking_pkg;
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE       = 3'd0;
    localparam state_t ST_EVAL       = 3'd1;
    localparam state_t ST_ADMIN_WAIT = 3'd2;
    localparam state_t ST_ADMIN_EVAL = 3'd3;
    localparam state_t ST_COMMIT     = 3'd4;
    localparam state_t ST_GATE       = 3'd5;
    localparam state_t ST_REPORT     = 3'd6;
    localparam logic [1:0] MODE_ENTER      = 2'd0;
    localparam logic [1:0] MODE_EXIT       = 2'd1;
    localparam logic [1:0] MODE_RESTRICT   = 2'd2;
    localparam logic [1:0] MODE_UNRESTRICT = 2'd3;
    localparam logic [2:0] ACT_NONE       = 3'd0;
    localparam logic [2:0] ACT_ALT        = 3'd1;
    localparam logic [2:0] ACT_CHOSEN     = 3'd2;
    localparam logic [2:0] ACT_EXIT       = 3'd3;
    localparam logic [2:0] ACT_RESTRICT   = 3'd4;
    localparam logic [2:0] ACT_UNRESTRICT = 3'd5;
    localparam logic [2:0] RES_ADMIN_OK   = 3'd0;
    localparam logic [2:0] RES_OK_CHOSEN  = 3'd1;
    localparam logic [2:0] RES_OK_ALT     = 3'd2;
    localparam logic [2:0] RES_OK_EXIT    = 3'd3;
    localparam logic [2:0] RES_FULL       = 3'd4;
    localparam logic [2:0] RES_DENIED     = 3'd5;
    localparam logic [2:0] RES_RESTRICTED = 3'd6;
    localparam logic [2:0] RES_TIMEOUT    = 3'd7;
    localparam logic [1:0] SEL_SPEC  = 2'd0;
    localparam logic [1:0] SEL_NORM0 = 2'd1;
    localparam logic [1:0] SEL_FLR1  = 2'd2;
    localparam logic [1:0] SEL_NONE  = 2'd3;
    typedef struct packed {
        logic [2:0] act;
        logic [1:0] sel;
        logic [2:0] res;
    } decision_t;
    function automatic decision_t decide(input logic [2:0] act, input logic [1:0] sel, input logic [2:0] res);
        return '{act: act, sel: sel, res: res};
    endfunction
endpackage

// File: rtl/parking_gate_ctrl_if.sv
// parking_gate_ctrl_if: gate request, lookup-block status/command and completion signals
interface parking_gate_ctrl_if;
    logic        req;
    logic [27:0] req_id;
    logic [1:0]  req_mode;
    logic        req_flr;
    logic        id_valid, id_special, chosen_flr_full, alternative_flr_full;
    logic        adminId_valid, id_restricted, id_exists, user_in_floor;
    logic [27:0] ID;
    logic [1:0]  MODE;
    logic        chosen_flr;
    logic [2:0]  action_taken;
    logic [2:0]  remain_flr_spec_0, remain_flr_norm_0, remain_flr_1;
    logic        gate_open, busy, done;
    logic [2:0]  result;
    modport master (
        output req, req_id, req_mode, req_flr,
        output id_valid, id_special, chosen_flr_full, alternative_flr_full,
        output adminId_valid, id_restricted, id_exists, user_in_floor,
        input  ID, MODE, chosen_flr, action_taken,
        input  remain_flr_spec_0, remain_flr_norm_0, remain_flr_1,
        input  gate_open, busy, done, result
    );
    modport slave (
        input  req, req_id, req_mode, req_flr,
        input  id_valid, id_special, chosen_flr_full, alternative_flr_full,
        input  adminId_valid, id_restricted, id_exists, user_in_floor,
        output ID, MODE, chosen_flr, action_taken,
        output remain_flr_spec_0, remain_flr_norm_0, remain_flr_1,
        output gate_open, busy, done, result
    );
endinterface

// File: rtl/floor_slot_counter.sv
// floor_slot_counter: free-slot count for one floor, starts full at CAP and saturates at 0 and CAP
module floor_slot_counter #(
    parameter int CAP = 7
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       dec,
    input  logic       inc,
    output logic [2:0] cnt
);
    always_ff @(posedge CLK) begin
        if (RST) cnt <= 3'(CAP);
        else if (dec && cnt != 3'd0) cnt <= cnt - 3'd1;
        else if (inc && cnt != 3'(CAP)) cnt <= cnt + 3'd1;
    end
endmodule

// File: rtl/parking_gate_ctrl.sv
// parking_gate_ctrl: sequences one gate request through the lookup block, owns the slot counters and gate timer.
// PARKING_ADMIN_TIMEOUT_EN: when defined, an admin request waiting ADMIN_TIMEOUT cycles for its target ends with TIMEOUT.
module parking_gate_ctrl #(
    parameter int SPEC_CAP      = 2,
    parameter int NORM0_CAP     = 5,
    parameter int FLR1_CAP      = 7,
    parameter int GATE_CYCLES   = 8,
    parameter int ADMIN_TIMEOUT = 64
) (
    input logic CLK,
    input logic RST,
    parking_gate_ctrl_if.slave bus
);
    import parking_pkg::*;
`ifdef PARKING_ADMIN_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif
    localparam int GW = $clog2(GATE_CYCLES + 1);
    localparam int TW = $clog2(ADMIN_TIMEOUT + 1);
    state_t state, state_n;
    logic [27:0] id_q;
    logic [1:0] mode_q;
    logic flr_q;
    decision_t dec_q, dec_n;
    logic [GW-1:0] gate_cnt;
    logic [TW-1:0] wait_cnt;
    logic [2:0] spec_rem, norm0_rem, flr1_rem;
    logic is_admin, timed_out, gate_done, commit, take, give;
    assign is_admin  = mode_q == MODE_RESTRICT || mode_q == MODE_UNRESTRICT;
    assign timed_out = TIMEOUT_EN && wait_cnt == TW'(ADMIN_TIMEOUT - 1);
    assign gate_done = gate_cnt == GW'(GATE_CYCLES - 1);
    // Lookup flags are judged straight off the latched ID/MODE/floor in EVAL and ADMIN_EVAL.
    always_comb begin
        dec_n = decide(ACT_NONE, SEL_NONE, RES_DENIED);
        if (state == ST_ADMIN_EVAL)
            dec_n = bus.id_exists ? decide(mode_q == MODE_RESTRICT ? ACT_RESTRICT : ACT_UNRESTRICT, SEL_NONE, RES_ADMIN_OK) : dec_n;
        else if (mode_q == MODE_ENTER) begin
            if (bus.id_special)
                dec_n = spec_rem != 3'd0 ? decide(ACT_CHOSEN, SEL_SPEC, RES_OK_CHOSEN) : decide(ACT_NONE, SEL_NONE, RES_FULL);
            else if (bus.id_valid)
                dec_n = !bus.chosen_flr_full ? decide(ACT_CHOSEN, flr_q ? SEL_FLR1 : SEL_NORM0, RES_OK_CHOSEN)
                      : !bus.alternative_flr_full ? decide(ACT_ALT, flr_q ? SEL_NORM0 : SEL_FLR1, RES_OK_ALT)
                      : decide(ACT_NONE, SEL_NONE, RES_FULL);
            else if (bus.id_restricted)
                dec_n = decide(ACT_NONE, SEL_NONE, RES_RESTRICTED);
        end else if (mode_q == MODE_EXIT && (bus.id_special || bus.id_valid))
            dec_n = decide(ACT_EXIT, bus.id_special ? SEL_SPEC : bus.user_in_floor ? SEL_FLR1 : SEL_NORM0, RES_OK_EXIT);
    end
    always_comb begin
        state_n = ST_IDLE;
        case (state)
            ST_IDLE:       state_n = bus.req ? ST_EVAL : ST_IDLE;
            ST_EVAL:       state_n = is_admin ? (bus.adminId_valid ? ST_ADMIN_WAIT : ST_REPORT)
                                              : (dec_n.act != ACT_NONE ? ST_COMMIT : ST_REPORT);
            ST_ADMIN_WAIT: state_n = bus.req ? ST_ADMIN_EVAL : timed_out ? ST_REPORT : ST_ADMIN_WAIT;
            ST_ADMIN_EVAL: state_n = dec_n.act != ACT_NONE ? ST_COMMIT : ST_REPORT;
            ST_COMMIT:     state_n = dec_q.sel == SEL_NONE ? ST_REPORT : ST_GATE;
            ST_GATE:       state_n = gate_done ? ST_REPORT : ST_GATE;
            default:       state_n = ST_IDLE;
        endcase
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_IDLE;
            id_q     <= '0;
            mode_q   <= '0;
            flr_q    <= 1'b0;
            dec_q    <= decide(ACT_NONE, SEL_NONE, RES_ADMIN_OK);
            gate_cnt <= '0;
            wait_cnt <= '0;
        end else begin
            state <= state_n;
            if (state == ST_IDLE && bus.req) begin
                id_q   <= bus.req_id;
                mode_q <= bus.req_mode;
                flr_q  <= bus.req_flr;
            end
            if (state == ST_ADMIN_WAIT && bus.req) id_q <= bus.req_id;
            if (state == ST_EVAL || state == ST_ADMIN_EVAL) dec_q <= dec_n;
            if (state == ST_ADMIN_WAIT && !bus.req && timed_out) dec_q.res <= RES_TIMEOUT;
            gate_cnt <= state == ST_GATE ? gate_cnt + 1'b1 : '0;
            wait_cnt <= state == ST_ADMIN_WAIT ? wait_cnt + 1'b1 : '0;
        end
    end
    // Counters move on the edge that closes COMMIT; admin grants select no counter.
    assign commit = state == ST_COMMIT;
    assign take   = commit && dec_q.act != ACT_EXIT;
    assign give   = commit && dec_q.act == ACT_EXIT;
    floor_slot_counter #(.CAP(SPEC_CAP)) u_spec (
        .CLK(CLK), .RST(RST),
        .dec(take && dec_q.sel == SEL_SPEC), .inc(give && dec_q.sel == SEL_SPEC), .cnt(spec_rem)
    );
    floor_slot_counter #(.CAP(NORM0_CAP)) u_norm0 (
        .CLK(CLK), .RST(RST),
        .dec(take && dec_q.sel == SEL_NORM0), .inc(give && dec_q.sel == SEL_NORM0), .cnt(norm0_rem)
    );
    floor_slot_counter #(.CAP(FLR1_CAP)) u_flr1 (
        .CLK(CLK), .RST(RST),
        .dec(take && dec_q.sel == SEL_FLR1), .inc(give && dec_q.sel == SEL_FLR1), .cnt(flr1_rem)
    );
    assign bus.ID                = id_q;
    assign bus.MODE              = mode_q;
    assign bus.chosen_flr        = flr_q;
    assign bus.action_taken      = commit ? dec_q.act : ACT_NONE;
    assign bus.remain_flr_spec_0 = spec_rem;
    assign bus.remain_flr_norm_0 = norm0_rem;
    assign bus.remain_flr_1      = flr1_rem;
    assign bus.gate_open         = state == ST_GATE;
    assign bus.busy              = state != ST_IDLE;
    assign bus.done              = state == ST_REPORT;
    assign bus.result            = dec_q.res;
endmodule
